// File: rtl/seq_1011_frame_tx_if.sv
// seq_1011_frame_tx_if
//   Bundles the payload handshake and the serial-side outputs of the
//   1011 frame transmitter.
//   master : payload source / line observer (drives din, din_valid)
//   slave  : the transmitter (drives din_ready, tx, tx_en, busy, frame_done)
//   Signals:
//     din[DATA_W]  payload word
//     din_valid    payload word present
//     din_ready    transmitter can accept din this cycle
//     tx           serial line, sync word then payload, MSB first
//     tx_en        tx carries a frame bit
//     busy         frame in flight
//     frame_done   high during the last bit cycle of a frame
interface seq_1011_frame_tx_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] din;
   logic              din_valid;
   logic              din_ready;
   logic              tx;
   logic              tx_en;
   logic              busy;
   logic              frame_done;

   modport master (
      output din, din_valid,
      input  din_ready, tx, tx_en, busy, frame_done
   );

   modport slave (
      input  din, din_valid,
      output din_ready, tx, tx_en, busy, frame_done
   );
endinterface

// File: rtl/seq_1011_frame_tx.sv
// seq_1011_frame_tx
//   Serial framer: accepts a DATA_W payload over valid/ready and sends
//   SYNC (MSB first) followed by the payload (MSB first) on a one-bit line.
//   Back-to-back frames are supported by accepting during the last bit cycle.
//   Optional macro FRAME_TX_PARITY_EN appends one even-parity bit per frame.
//   Ports:
//     clk  clock, posedge
//     rst  synchronous reset, active low
//     bus  seq_1011_frame_tx_if.slave (din/din_valid in; din_ready, tx,
//          tx_en, busy, frame_done out; all outputs but din_ready registered)
module seq_1011_frame_tx #(
   parameter int                DATA_W = 8,
   parameter int                SYNC_W = 4,
   parameter logic [SYNC_W-1:0] SYNC   = 4'b1011
) (
   input logic               clk,
   input logic               rst,
   seq_1011_frame_tx_if.slave bus
);

   localparam int FW = SYNC_W + DATA_W;
   localparam int CW = $clog2(((SYNC_W > DATA_W) ? SYNC_W : DATA_W) + 1);
   localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_W - 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
`ifndef FRAME_TX_PARITY_EN
   // Data count at which the next cycle is the closing bit.
   localparam logic [CW-1:0] DATA_PEN  = CW'(DATA_W - 2);
`endif

`ifdef FRAME_TX_PARITY_EN
   typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_PAR} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA} state_t;
`endif

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [FW-1:0]   sr;        // {SYNC, payload}; sr[FW-2] is always the next bit
   logic            tx_q, tx_en_q, busy_q, done_q;
   logic            last, accept;
`ifdef FRAME_TX_PARITY_EN
   logic            par_q;
`endif

`ifdef FRAME_TX_PARITY_EN
   assign last = (state == S_PAR);
`else
   assign last = (state == S_DATA) && (cnt == DATA_LAST);
`endif

   assign bus.din_ready  = (state == S_IDLE) || last;
   assign accept         = bus.din_valid && bus.din_ready;
   assign bus.tx         = tx_q;
   assign bus.tx_en      = tx_en_q;
   assign bus.busy       = busy_q;
   assign bus.frame_done = done_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         sr      <= '0;
         tx_q    <= 1'b0;
         tx_en_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef FRAME_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else if (accept) begin
         // Accept only happens in IDLE or the closing bit, so this also
         // chains the next frame with no gap on tx_en.
         state   <= S_SYNC;
         cnt     <= '0;
         sr      <= {SYNC, bus.din};
         tx_q    <= SYNC[SYNC_W-1];
         tx_en_q <= 1'b1;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
`ifdef FRAME_TX_PARITY_EN
         par_q   <= ^bus.din;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            S_SYNC: begin
               tx_q <= sr[FW-2];
               sr   <= sr << 1;
               if (cnt == SYNC_LAST) begin
                  state <= S_DATA;
                  cnt   <= '0;
`ifndef FRAME_TX_PARITY_EN
                  done_q <= (DATA_W == 1);
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (cnt == DATA_LAST) begin
`ifdef FRAME_TX_PARITY_EN
                  state  <= S_PAR;
                  cnt    <= '0;
                  tx_q   <= par_q;
                  done_q <= 1'b1;
`else
                  state   <= S_IDLE;
                  cnt     <= '0;
                  tx_q    <= 1'b0;
                  tx_en_q <= 1'b0;
                  busy_q  <= 1'b0;
`endif
               end else begin
                  cnt  <= cnt + 1'b1;
                  tx_q <= sr[FW-2];
                  sr   <= sr << 1;
`ifndef FRAME_TX_PARITY_EN
                  done_q <= (cnt == DATA_PEN);
`endif
               end
            end
            default: begin
               // IDLE, or closing parity bit with nothing waiting
               state   <= S_IDLE;
               cnt     <= '0;
               tx_q    <= 1'b0;
               tx_en_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_1011_frame_tx.sv
module tb_seq_1011_frame_tx;
   localparam int DW = 8;
`ifdef FRAME_TX_PARITY_EN
   localparam int FL = 13;
`else
   localparam int FL = 12;
`endif

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   seq_1011_frame_tx_if #(.DATA_W(DW)) bus();
   seq_1011_frame_tx #(.DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

   // {tx, tx_en, busy, frame_done, din_ready}
   logic [4:0] obs;
   assign obs = {bus.tx, bus.tx_en, bus.busy, bus.frame_done, bus.din_ready};

   // Frame bit k lives at f[12-k]; the parity bit only matters when enabled.
   function automatic logic [12:0] frame_bits(input logic [7:0] d);
      return {4'b1011, d, ^d};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      bus.din = 8'hFF;
      bus.din_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick;
         checks++;
         if (obs !== 5'b00001) begin
            errors++;
            $display("FAIL reset cyc=%0d got=%b exp=%b", i, obs, 5'b00001);
         end
      end
      bus.din_valid = 1'b0;
      rst = 1'b1;
      tick;
      checks++;
      if (obs !== 5'b00001) begin
         errors++;
         $display("FAIL reset_no_frame got=%b exp=%b", obs, 5'b00001);
      end
   endtask

   task automatic test_single(input logic [7:0] d);
      logic [12:0] f;
      logic [3:0]  hist;
      logic [4:0]  exp;
      f = frame_bits(d);
      hist = 4'b0000;
      bus.din = d;
      bus.din_valid = 1'b1;
      checks++;
      if (bus.din_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_ready din=%h got=%b exp=1", d, bus.din_ready);
      end
      tick;
      bus.din_valid = 1'b0;
      bus.din = 8'h00;
      for (int k = 0; k < FL; k++) begin
         exp = {f[12-k], 1'b1, 1'b1, (k == FL-1), (k == FL-1)};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL single din=%h k=%0d got=%b exp=%b", d, k, obs, exp);
         end
         hist = {hist[2:0], bus.tx};
         if (k == 3) begin
            checks++;
            if (hist !== 4'b1011) begin
               errors++;
               $display("FAIL sync_detect din=%h got=%b exp=1011", d, hist);
            end
         end
         tick;
      end
      checks++;
      if (obs !== 5'b00001) begin
         errors++;
         $display("FAIL single_idle din=%h got=%b exp=%b", d, obs, 5'b00001);
      end
   endtask

   task automatic test_back_to_back;
      logic [12:0] f1, f2;
      logic [4:0]  exp;
      logic        b, last;
      f1 = frame_bits(8'h3C);
      f2 = frame_bits(8'hFF);
      bus.din = 8'h3C;
      bus.din_valid = 1'b1;
      tick;
      bus.din = 8'hFF;
      for (int k = 0; k < 2*FL; k++) begin
         b = (k < FL) ? f1[12-k] : f2[12-(k-FL)];
         last = (k == FL-1) || (k == 2*FL-1);
         exp = {b, 1'b1, 1'b1, last, last};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL b2b k=%0d got=%b exp=%b", k, obs, exp);
         end
         tick;
         if (k == FL-1) bus.din_valid = 1'b0;
      end
      checks++;
      if (obs !== 5'b00001) begin
         errors++;
         $display("FAIL b2b_idle got=%b exp=%b", obs, 5'b00001);
      end
   endtask

   task automatic test_handshake;
      logic [12:0] f;
      logic [4:0]  exp;
      f = frame_bits(8'h5A);
      bus.din = 8'h5A;
      bus.din_valid = 1'b1;
      tick;
      bus.din_valid = 1'b0;
      bus.din = 8'h00;
      for (int k = 0; k < FL; k++) begin
         if (k == 4) begin
            bus.din = 8'hEE;
            bus.din_valid = 1'b1;
         end
         exp = {f[12-k], 1'b1, 1'b1, (k == FL-1), (k == FL-1)};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL handshake k=%0d got=%b exp=%b", k, obs, exp);
         end
         tick;
         if (k == 4) begin
            bus.din_valid = 1'b0;
            bus.din = 8'h00;
         end
      end
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (obs !== 5'b00001) begin
            errors++;
            $display("FAIL handshake_no_second cyc=%0d got=%b exp=%b", i, obs, 5'b00001);
         end
         tick;
      end
   endtask

   task automatic test_midreset;
      logic [12:0] f;
      logic [4:0]  exp;
      f = frame_bits(8'hC3);
      bus.din = 8'hC3;
      bus.din_valid = 1'b1;
      tick;
      bus.din_valid = 1'b0;
      for (int k = 0; k < 7; k++) begin
         exp = {f[12-k], 1'b1, 1'b1, 1'b0, 1'b0};
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL midreset_pre k=%0d got=%b exp=%b", k, obs, exp);
         end
         if (k == 6) rst = 1'b0;
         tick;
      end
      checks++;
      if (obs !== 5'b00001) begin
         errors++;
         $display("FAIL midreset_state got=%b exp=%b", obs, 5'b00001);
      end
      rst = 1'b1;
      tick;
      test_single(8'h01);
   endtask

   initial begin
      rst = 1'b0;
      bus.din = '0;
      bus.din_valid = 1'b0;
      test_reset;
      test_single(8'hA5);
      test_single(8'h07);
      test_back_to_back;
      test_handshake;
      test_midreset;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_1011_frame_tx.md
Name: seq_1011_frame_tx

Overview:
- Serial frame transmitter that produces the bit stream consumed by the 1011 sequence detectors.
- Accepts a parallel payload word over a valid/ready handshake.
- Serializes it onto a one-bit line as the 4-bit sync word 1011 (MSB first), then the payload MSB first.
- Sits upstream of the detector FSMs; used as a stimulus source and as the link-side framer.

Parameters:
- DATA_W, 8, payload width in bits (legal range 1..32).
- SYNC_W, 4, sync word width in bits.
- SYNC, 4'b1011, sync word, transmitted MSB first.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous reset, active-low; sampled only on posedge clk.
- din  input  DATA_W  payload word; sampled on an accept edge.
- din_valid  input  1  payload word present.
- din_ready  output  1  transmitter can accept din this cycle.
- tx  output  DATA_W-independent 1  serial line (x of the detector); registered.
- tx_en  output  1  high while tx carries a frame bit; registered.
- busy  output  1  high from the accept edge until the last frame bit completes.
- frame_done  output  1  one-cycle pulse, high during the last bit cycle of a frame.

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, tx=0, tx_en=0, busy=0, frame_done=0, bit counter=0. Any frame in flight is discarded with no partial completion; din_ready=1 from the next cycle.
- Accept: a word is accepted at a posedge where din_valid=1 and din_ready=1. din is latched into the shift register. With din_ready=0, din_valid is ignored and nothing is latched.
- din_ready is combinational from state. It is 1 in IDLE, and 1 during the last bit cycle of a frame (back-to-back support). It is 0 otherwise.
- Latency: first sync bit appears on tx in the cycle immediately after the accept edge.
- FSM states and transitions:
  - IDLE: tx=0, tx_en=0. On accept -> SYNC; tx<=SYNC[SYNC_W-1], tx_en<=1.
  - SYNC: shifts out SYNC_W bits, one per clock. After the last sync bit -> DATA, driving din[DATA_W-1] first.
  - DATA: shifts out DATA_W bits, MSB first. After the last bit -> PARITY if enabled, else -> IDLE or SYNC (see below).
  - PARITY: exists only with the optional feature; one bit.
- Last bit cycle: frame_done=1 and din_ready=1.
  - If an accept occurs at the closing edge, the next cycle carries the new SYNC MSB. tx_en stays 1 with no gap.
  - With no accept, the state goes to IDLE and tx=0, tx_en=0 on the next cycle.
- Frame length: SYNC_W+DATA_W cycles, +1 with parity. tx_en is high for exactly that many cycles per frame.
- busy=1 in SYNC/DATA/PARITY; 0 in IDLE.
- Counter width: clog2(max(SYNC_W,DATA_W)+1). Counter wraps to 0 at every state change.
- No payload scrambling. Payload bits matching 1011 are transmitted as-is; detector hits inside the payload are legal.
- rst=0 coinciding with an accept: reset wins and the word is not latched.

Optional Feature:
- Macro FRAME_TX_PARITY_EN.
- Defined: a PARITY state follows DATA and transmits the even-parity bit (XOR of all DATA_W payload bits). Frame = SYNC_W+DATA_W+1 cycles; frame_done and din_ready move to the parity cycle.
- Undefined: no PARITY state, no parity logic; frame = SYNC_W+DATA_W cycles.

Test Plan:
- Reset: hold rst=0 for 2 cycles with din_valid=1 -> tx=0, tx_en=0, busy=0, frame_done=0, din_ready=1; no frame starts.
- Single frame, din=8'hA5 -> starting the cycle after the accept, tx = 1,0,1,1,1,0,1,0,0,1,0,1. tx_en is high for 12 cycles, frame_done is high only in cycle 12, then the block returns to IDLE.
- Back-to-back, din=8'h3C then 8'hFF with din_valid held -> 24 contiguous tx_en cycles. tx = 1011 00111100 1011 11111111, frame_done pulses in cycles 12 and 24.
- Handshake: din_valid pulsed during bit 5 of a frame -> ignored; second frame is not sent and din is not latched.
- Mid-frame reset during data bit 3 -> tx=0 and tx_en=0 after that edge, din_ready=1. A new accept of 8'h01 then sends a clean frame 1011 00000001.
- FRAME_TX_PARITY_EN defined:
  - din=8'hA5 -> 13-bit frame ending in parity 0.
  - din=8'h07 -> parity bit 1.
  - In both cases frame_done is in cycle 13, and a bench 1011 detector model flags the sync in every frame.
